// File: rtl/seq_multiplier_pkg.sv
// Shared constants and FSM state encoding for the sequential multiply/divide control.
package seq_multiplier_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/product_reg.sv
// Product register with shift-and-add datapath: one conditional add + right shift per step.
// The carry out of the add lands in the MSB, so the shift never loses it.
module product_reg
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mplier_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) sum = sum + {1'b0, mcand_i};
    prod_d = prod_q;
    if (load_i) begin
      prod_d = {{WIDTH{1'b0}}, mplier_i};
    end else if (step_i) begin
      prod_d = {sum, prod_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else        prod_q <= prod_d;
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned WIDTH x WIDTH sequential multiplier; Rdy rises WIDTH+1 edges after the Run edge.
// Run is only accepted in IDLE/DONE; a request while BUSY is dropped.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Mcand,
  input  logic [WIDTH-1:0] Mplier,
  input  logic             Run,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Rdy
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             load, step;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Run) begin
          mcand_d = Mcand;
          cnt_d   = '0;
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Count WIDTH shift steps, then spend one more BUSY cycle to publish the result.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH)) state_d = DONE;
        else                     step    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
    end
  end

  product_reg #(.WIDTH(WIDTH)) u_product_reg (
    .clk      (clk),
    .rst_n    (Rst),
    .load_i   (load),
    .step_i   (step),
    .mplier_i (Mplier),
    .mcand_i  (mcand_q),
    .prod_o   (prod)
  );

  assign Hi  = prod[2*WIDTH-1:WIDTH];
  assign Lo  = prod[WIDTH-1:0];
  assign Rdy = (state_q == DONE);

endmodule
